// File: rtl/reset_sequencer.sv
// reset_sequencer
// Multi-channel reset synchronizer and ordered release sequencer.
// Each active-low request is synchronized into dest_clk. Any request holds
// every domain reset asserted for at least MIN_ASSERT cycles after the last
// request clears. The resets are then released one channel at a time,
// channel 0 first, with RELEASE_GAP cycles between releases.
// Optional feature macro: RESET_SEQ_SW_REQ_EN adds the sw_rst_req input and
// the sw_cause output.
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int STAGES      = 3,
  parameter int MIN_ASSERT  = 16,
  parameter int RELEASE_GAP = 8
) (
  input  logic              dest_clk,
  input  logic              dest_rst,
  input  logic [NUM_CH-1:0] src_resetn,
`ifdef RESET_SEQ_SW_REQ_EN
  input  logic              sw_rst_req,
  output logic              sw_cause,
`endif
  output logic [NUM_CH-1:0] dest_resetn,
  output logic              seq_done,
  output logic [NUM_CH-1:0] last_cause
);

  localparam int HOLD_W = (MIN_ASSERT  > 1) ? $clog2(MIN_ASSERT + 1)  : 1;
  localparam int GAP_W  = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP + 1) : 1;
  localparam int IDX_W  = (NUM_CH      > 1) ? $clog2(NUM_CH + 1)      : 1;

  // The cause vector carries one extra bit for the software request when
  // that feature is built in, so both cause outputs share one register.
`ifdef RESET_SEQ_SW_REQ_EN
  localparam int CW = NUM_CH + 1;
`else
  localparam int CW = NUM_CH;
`endif

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

  logic [STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [CW-1:0]     req_all;
  logic              any_req;

  state_t            state_q, state_n;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_n;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [NUM_CH-1:0] resetn_q, resetn_n;
  logic              done_q, done_n;
  logic [CW-1:0]     cause_q, cause_n;
  logic              armed_q, armed_n;

  // Synchronizer chains; the reset value of 0 reads as an active request.
  always_ff @(posedge dest_clk) begin
    if (dest_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {sync_q[i][STAGES-2:0], src_resetn[i]};
      end
    end
  end

  // Active-high request per channel, taken from the last synchronizer stage.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i] = ~sync_q[i][STAGES-1];
    end
  end

`ifdef RESET_SEQ_SW_REQ_EN
  assign req_all  = {sw_rst_req, req};
  assign sw_cause = cause_q[NUM_CH];
`else
  assign req_all  = req;
`endif

  assign any_req = |req_all;

  // State, counters and all registered outputs.
  always_ff @(posedge dest_clk) begin
    if (dest_rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      resetn_q   <= '0;
      done_q     <= 1'b0;
      cause_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      hold_cnt_q <= hold_cnt_n;
      gap_cnt_q  <= gap_cnt_n;
      idx_q      <= idx_n;
      resetn_q   <= resetn_n;
      done_q     <= done_n;
      cause_q    <= cause_n;
      armed_q    <= armed_n;
    end
  end

  // Next-state and next-output logic. The cause only accumulates in an
  // episode started by a real request (armed); the hold that follows
  // dest_rst is not attributed to any channel, because the synchronizer
  // reset value would otherwise look like a request on every channel.
  always_comb begin
    state_n    = state_q;
    hold_cnt_n = hold_cnt_q;
    gap_cnt_n  = gap_cnt_q;
    idx_n      = idx_q;
    resetn_n   = resetn_q;
    done_n     = done_q;
    cause_n    = cause_q;
    armed_n    = armed_q;

    case (state_q)
      HOLD: begin
        resetn_n  = '0;
        done_n    = 1'b0;
        gap_cnt_n = '0;
        idx_n     = '0;
        if (armed_q) begin
          cause_n = cause_q | req_all;
        end
        if (any_req) begin
          hold_cnt_n = '0;
        end else if (hold_cnt_q == HOLD_W'(MIN_ASSERT - 1)) begin
          state_n    = RELEASE;
          hold_cnt_n = '0;
          resetn_n   = NUM_CH'(1);
        end else begin
          hold_cnt_n = hold_cnt_q + HOLD_W'(1);
        end
      end

      RELEASE: begin
        if (any_req) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
          gap_cnt_n  = '0;
          idx_n      = '0;
          resetn_n   = '0;
          done_n     = 1'b0;
          cause_n    = req_all;
          armed_n    = 1'b1;
        end else if (gap_cnt_q == GAP_W'(RELEASE_GAP - 1)) begin
          gap_cnt_n = '0;
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_n  = RUN;
            resetn_n = '1;
            done_n   = 1'b1;
          end else begin
            idx_n    = idx_q + IDX_W'(1);
            resetn_n = resetn_q | (NUM_CH'(1) << (idx_q + IDX_W'(1)));
          end
        end else begin
          gap_cnt_n = gap_cnt_q + GAP_W'(1);
        end
      end

      RUN: begin
        resetn_n = '1;
        done_n   = 1'b1;
        if (any_req) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
          gap_cnt_n  = '0;
          idx_n      = '0;
          resetn_n   = '0;
          done_n     = 1'b0;
          cause_n    = req_all;
          armed_n    = 1'b1;
        end
      end

      default: begin
        state_n    = HOLD;
        hold_cnt_n = '0;
        resetn_n   = '0;
        done_n     = 1'b0;
      end
    endcase
  end

  assign dest_resetn = resetn_q;
  assign seq_done    = done_q;
  assign last_cause  = cause_q[NUM_CH-1:0];

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer with its default parameters.
// Expected output snapshots are queued with the edge number they belong to
// whenever stimulus is driven. A monitor pops each snapshot on the falling
// edge after that clock edge and compares it with the DUT outputs.
// Build with RESET_SEQ_SW_REQ_EN defined to also cover the software request.
module tb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] resetn;
    logic       done;
    logic [3:0] cause;
    logic       sw;
  } sb_entry_t;

  localparam int NO_LIMIT = 1000000;

  logic       dest_clk;
  logic       dest_rst;
  logic [3:0] src_resetn;
  logic [3:0] dest_resetn;
  logic       seq_done;
  logic [3:0] last_cause;
`ifdef RESET_SEQ_SW_REQ_EN
  logic       sw_rst_req;
  logic       sw_cause;
`endif

  int        edge_cnt = 0;
  int        total    = 0;
  int        bad      = 0;
  sb_entry_t sb[$];
  sb_entry_t cur;

  reset_sequencer #(
    .NUM_CH     (4),
    .STAGES     (3),
    .MIN_ASSERT (16),
    .RELEASE_GAP(8)
  ) dut (
    .dest_clk   (dest_clk),
    .dest_rst   (dest_rst),
    .src_resetn (src_resetn),
`ifdef RESET_SEQ_SW_REQ_EN
    .sw_rst_req (sw_rst_req),
    .sw_cause   (sw_cause),
`endif
    .dest_resetn(dest_resetn),
    .seq_done   (seq_done),
    .last_cause (last_cause)
  );

  // Free-running clock.
  initial begin
    dest_clk = 1'b0;
    forever #5 dest_clk = ~dest_clk;
  end

  // Number of rising edges seen so far.
  always @(posedge dest_clk) begin
    edge_cnt <= edge_cnt + 1;
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic push_exp(input int cyc, input logic [3:0] resetn, input logic done,
                          input logic [3:0] cause, input logic sw, input int last);
    sb_entry_t e;
    if (cyc <= last) begin
      e.cyc    = cyc;
      e.resetn = resetn;
      e.done   = done;
      e.cause  = cause;
      e.sw     = sw;
      sb.push_back(e);
    end
  endtask

  // Snapshots of one full release sequence, channel 0 releasing at edge base.
  task automatic push_release(input int base, input logic [3:0] cause,
                              input logic sw, input int last);
    push_exp(base - 1,  4'b0000, 1'b0, cause, sw, last);
    push_exp(base,      4'b0001, 1'b0, cause, sw, last);
    push_exp(base + 7,  4'b0001, 1'b0, cause, sw, last);
    push_exp(base + 8,  4'b0011, 1'b0, cause, sw, last);
    push_exp(base + 16, 4'b0111, 1'b0, cause, sw, last);
    push_exp(base + 24, 4'b1111, 1'b0, cause, sw, last);
    push_exp(base + 31, 4'b1111, 1'b0, cause, sw, last);
    push_exp(base + 32, 4'b1111, 1'b1, cause, sw, last);
  endtask

  task automatic wait_until(input int n);
    while (edge_cnt < n) @(negedge dest_clk);
  endtask

  // Drive inputs on the falling edge that follows rising edge n.
  task automatic applyStimulus(input int n, input logic [3:0] src, input logic rst,
                               input logic sw);
    wait_until(n);
    src_resetn = src;
    dest_rst   = rst;
`ifdef RESET_SEQ_SW_REQ_EN
    sw_rst_req = sw;
`else
    if (sw) $display("[TB] note: software request ignored in this build");
`endif
  endtask

  // Compare every snapshot due at the current edge.
  always @(negedge dest_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      cur = sb.pop_front();
      if (cur.cyc < edge_cnt) begin
        checkOutput("sb_late", edge_cnt, cur.cyc);
      end else begin
        checkOutput($sformatf("resetn@%0d", cur.cyc), dest_resetn, cur.resetn);
        checkOutput($sformatf("done@%0d", cur.cyc), seq_done, cur.done);
        checkOutput($sformatf("cause@%0d", cur.cyc), last_cause, cur.cause);
`ifdef RESET_SEQ_SW_REQ_EN
        checkOutput($sformatf("sw_cause@%0d", cur.cyc), sw_cause, cur.sw);
`endif
      end
    end
  end

  // Scenario sequence; edge numbers count rising edges from time zero.
  initial begin
    dest_rst   = 1'b1;
    src_resetn = 4'hF;
`ifdef RESET_SEQ_SW_REQ_EN
    sw_rst_req = 1'b0;
`endif

    // Power-on: reset for edges 1..5, then 3 sync edges plus 16 hold edges.
    push_exp(5, 4'b0000, 1'b0, 4'b0000, 1'b0, NO_LIMIT);
    push_release(24, 4'b0000, 1'b0, NO_LIMIT);
    applyStimulus(5, 4'hF, 1'b0, 1'b0);

    // Channel 2 request in RUN, 10 cycles long.
    applyStimulus(60, 4'b1011, 1'b0, 1'b0);
    push_exp(63, 4'b1111, 1'b1, 4'b0000, 1'b0, NO_LIMIT);
    push_exp(64, 4'b0000, 1'b0, 4'b0100, 1'b0, NO_LIMIT);
    applyStimulus(70, 4'hF, 1'b0, 1'b0);
    push_exp(80, 4'b0000, 1'b0, 4'b0100, 1'b0, NO_LIMIT);
    push_release(89, 4'b0100, 1'b0, 100);

    // Channel 0 request after channel 1 has been released.
    applyStimulus(100, 4'b1110, 1'b0, 1'b0);
    push_exp(103, 4'b0011, 1'b0, 4'b0100, 1'b0, NO_LIMIT);
    push_exp(104, 4'b0000, 1'b0, 4'b0001, 1'b0, NO_LIMIT);
    applyStimulus(105, 4'hF, 1'b0, 1'b0);
    push_release(124, 4'b0001, 1'b0, NO_LIMIT);

    // Overlapping requests on channels 1 and 3.
    applyStimulus(160, 4'b1101, 1'b0, 1'b0);
    push_exp(163, 4'b1111, 1'b1, 4'b0001, 1'b0, NO_LIMIT);
    push_exp(164, 4'b0000, 1'b0, 4'b0010, 1'b0, NO_LIMIT);
    push_exp(169, 4'b0000, 1'b0, 4'b0010, 1'b0, NO_LIMIT);
    applyStimulus(166, 4'b0101, 1'b0, 1'b0);
    push_exp(170, 4'b0000, 1'b0, 4'b1010, 1'b0, NO_LIMIT);
    applyStimulus(172, 4'b0111, 1'b0, 1'b0);
    push_exp(175, 4'b0000, 1'b0, 4'b1010, 1'b0, NO_LIMIT);
    applyStimulus(176, 4'hF, 1'b0, 1'b0);
    push_release(195, 4'b1010, 1'b0, 205);

    // dest_rst in the middle of a release sequence.
    applyStimulus(205, 4'hF, 1'b1, 1'b0);
    push_exp(206, 4'b0000, 1'b0, 4'b0000, 1'b0, NO_LIMIT);
    push_exp(208, 4'b0000, 1'b0, 4'b0000, 1'b0, NO_LIMIT);
    applyStimulus(208, 4'hF, 1'b0, 1'b0);
    push_release(227, 4'b0000, 1'b0, NO_LIMIT);

    // Request arriving on the very edge the hold would have ended.
    applyStimulus(262, 4'b0111, 1'b0, 1'b0);
    push_exp(266, 4'b0000, 1'b0, 4'b1000, 1'b0, NO_LIMIT);
    applyStimulus(265, 4'hF, 1'b0, 1'b0);
    applyStimulus(280, 4'b0111, 1'b0, 1'b0);
    push_exp(283, 4'b0000, 1'b0, 4'b1000, 1'b0, NO_LIMIT);
    push_exp(284, 4'b0000, 1'b0, 4'b1000, 1'b0, NO_LIMIT);
    push_exp(285, 4'b0000, 1'b0, 4'b1000, 1'b0, NO_LIMIT);
    applyStimulus(285, 4'hF, 1'b0, 1'b0);
    push_release(304, 4'b1000, 1'b0, 332);

    // Request on the last release edge: back to hold, never RUN.
    applyStimulus(332, 4'b1110, 1'b0, 1'b0);
    push_exp(335, 4'b1111, 1'b0, 4'b1000, 1'b0, NO_LIMIT);
    push_exp(336, 4'b0000, 1'b0, 4'b0001, 1'b0, NO_LIMIT);
    push_exp(340, 4'b0000, 1'b0, 4'b0001, 1'b0, NO_LIMIT);
    applyStimulus(334, 4'hF, 1'b0, 1'b0);
    push_release(353, 4'b0001, 1'b0, NO_LIMIT);

`ifdef RESET_SEQ_SW_REQ_EN
    // One-cycle software request in RUN.
    applyStimulus(390, 4'hF, 1'b0, 1'b1);
    push_exp(391, 4'b0000, 1'b0, 4'b0000, 1'b1, NO_LIMIT);
    push_release(407, 4'b0000, 1'b1, NO_LIMIT);
    applyStimulus(391, 4'hF, 1'b0, 1'b0);
`endif

    wait_until(445);
    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
